hub75_capture: RTL and testbench

//   Receive-side model of a HUB75 panel. Oversamples the HUB75 bus (clock, strobe, OE, A-D row select, RGB) on the system clock.

---
 rtl/hub75_capture.sv | 153 +++++++++++++++
 tb/tb_hub75_capture.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: oversamples the panel bus on clk, rebuilds each
// latched row and streams it out as pixel writes, and measures OE-on time.
// Colour lanes are wired for two segments (R1/G1/B1, R2/G2/B2).
module hub75_capture #(
  parameter int hpixel_p   = 64,
  parameter int segments_p = 2,
  parameter int oe_cnt_w_p = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          I_CLK,
  input  logic                          STB,
  input  logic                          OE,
  input  logic                          A,
  input  logic                          B,
  input  logic                          C,
  input  logic                          D,
  input  logic                          R1,
  input  logic                          G1,
  input  logic                          B1,
  input  logic                          R2,
  input  logic                          G2,
  input  logic                          B2,
  output logic                          o_px_valid,
  input  logic                          i_px_ready,
  output logic [$clog2(16*hpixel_p)-1:0] o_px_addr,
  output logic [segments_p*3-1:0]       o_px_data,
  output logic                          o_oe_valid,
  output logic [oe_cnt_w_p-1:0]         o_oe_cycles,
  output logic [3:0]                    o_oe_row,
  output logic                          o_err_len,
  output logic                          o_err_ovr
);

  localparam int AW = $clog2(16*hpixel_p);
  localparam int DW = segments_p*3;
  localparam int IW = $clog2(hpixel_p);
  localparam int CW = $clog2(hpixel_p+1);
  localparam logic [CW-1:0] HP_C   = CW'(hpixel_p);
  localparam logic [IW-1:0] LAST_I = IW'(hpixel_p-1);
  localparam logic [AW-1:0] HP_A   = AW'(hpixel_p);

  // state | meaning
  // IDLE  | no row pending, waiting for a strobe
  // DRAIN | streaming latch_buf out as pixel writes
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [12:0]           bus_raw, sync1, sync2;
  logic [2:0]            edge_prev;
  logic [DW-1:0]         rgb;
  logic                  shift_rise, stb_rise, oe_fall, do_shift;
  logic [CW-1:0]         col_cnt, col_next;
  logic [DW-1:0]         shift_buf [hpixel_p];
  logic [DW-1:0]         latch_buf [hpixel_p];
  logic [0:0]            state;
  logic [IW-1:0]         col;
  logic [3:0]            row;
  logic [oe_cnt_w_p-1:0] oe_cnt;

  // All bus lines share one chain so data stays aligned with its clock edge.
  assign bus_raw    = {I_CLK, STB, OE, D, C, B, A, B2, G2, R2, B1, G1, R1};
  assign rgb        = sync2[DW-1:0];
  assign shift_rise = sync2[12] & ~edge_prev[2];
  assign stb_rise   = sync2[11] & ~edge_prev[1];
  assign oe_fall    = ~sync2[10] & edge_prev[0];
  assign do_shift   = shift_rise && (col_cnt != HP_C);
  assign col_next   = do_shift ? col_cnt + CW'(1) : col_cnt;

  // Two-stage synchroniser plus one delayed copy of the edge-sensitive lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      edge_prev <= '0;
    end else begin
      sync1     <= bus_raw;
      sync2     <= sync1;
      edge_prev <= sync2[12:10];
    end
  end

  // Shift register fill; a strobe always empties it, latched or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      for (int k = 0; k < hpixel_p; k++) shift_buf[k] <= '0;
    end else if (stb_rise) begin
      col_cnt <= '0;
      for (int k = 0; k < hpixel_p; k++) shift_buf[k] <= '0;
    end else if (do_shift) begin
      shift_buf[col_cnt[IW-1:0]] <= rgb;
      col_cnt <= col_next;
    end
  end

  // Latch and drain FSM; a shift coinciding with the strobe is folded in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      o_err_len <= 1'b0;
      o_err_ovr <= 1'b0;
      for (int k = 0; k < hpixel_p; k++) latch_buf[k] <= '0;
    end else begin
      o_err_len <= stb_rise && (col_next != HP_C);
      o_err_ovr <= stb_rise && (state == ST_DRAIN);
      if (state == ST_IDLE) begin
        if (stb_rise) begin
          state <= ST_DRAIN;
          row   <= sync2[9:6];
          col   <= '0;
          for (int k = 0; k < hpixel_p; k++)
            latch_buf[k] <= (do_shift && col_cnt == CW'(k)) ? rgb : shift_buf[k];
        end
      end else if (i_px_ready) begin
        if (col == LAST_I) begin
          state <= ST_IDLE;
          col   <= '0;
        end else begin
          col <= col + IW'(1);
        end
      end
    end
  end

  assign o_px_valid = (state == ST_DRAIN);
  assign o_px_addr  = o_px_valid ? AW'(row) * HP_A + AW'(col) : '0;
  assign o_px_data  = o_px_valid ? latch_buf[col] : '0;

  // OE-on duration counter, reported and cleared on the falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_cnt      <= '0;
      o_oe_valid  <= 1'b0;
      o_oe_cycles <= '0;
      o_oe_row    <= '0;
    end else begin
      o_oe_valid <= oe_fall;
      if (oe_fall) begin
        o_oe_cycles <= oe_cnt;
        o_oe_row    <= row;
      end
      if (sync2[10]) begin
        if (oe_cnt != '1) oe_cnt <= oe_cnt + oe_cnt_w_p'(1);
      end else begin
        oe_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: drives slow HUB75 traffic, predicts pixel writes,
// error pulses and OE reports from a row-level model.
module tb_hub75_capture;
  logic clk = 1'b0, rst = 1'b1;
  logic I_CLK = 0, STB = 0, OE = 0, A = 0, B = 0, C = 0, D = 0;
  logic R1 = 0, G1 = 0, B1 = 0, R2 = 0, G2 = 0, B2 = 0;
  logic i_px_ready = 1'b0;
  logic o_px_valid, o_oe_valid, o_err_len, o_err_ovr;
  logic [9:0] o_px_addr;
  logic [5:0] o_px_data;
  logic [15:0] o_oe_cycles;
  logic [3:0] o_oe_row;

  hub75_capture dut (
    .clk(clk), .rst(rst), .I_CLK(I_CLK), .STB(STB), .OE(OE),
    .A(A), .B(B), .C(C), .D(D),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
    .o_px_valid(o_px_valid), .i_px_ready(i_px_ready),
    .o_px_addr(o_px_addr), .o_px_data(o_px_data),
    .o_oe_valid(o_oe_valid), .o_oe_cycles(o_oe_cycles), .o_oe_row(o_oe_row),
    .o_err_len(o_err_len), .o_err_ovr(o_err_ovr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_len = 0, n_ovr = 0, n_oe = 0;
  logic [15:0] last_oe_cycles = '0;
  logic [3:0]  last_oe_row = '0;
  logic [5:0]  row_data [80];
  logic [5:0]  exp_px [64];
  int          exp_base = 0;
  bit          oe_noise = 0;

  // pulse bookkeeping
  always @(negedge clk) begin
    if (o_err_len === 1'b1) n_len++;
    if (o_err_ovr === 1'b1) n_ovr++;
    if (o_oe_valid === 1'b1) begin
      n_oe++;
      last_oe_cycles = o_oe_cycles;
      last_oe_row    = o_oe_row;
    end
  end

  task automatic hub_shift(input logic [5:0] d);
    {B2, G2, R2, B1, G1, R1} = d;
    if (oe_noise) OE = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
    I_CLK = 1'b1;
    repeat (3) @(negedge clk);
    I_CLK = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic hub_stb(input logic [3:0] r);
    {D, C, B, A} = r;
    repeat (2) @(negedge clk);
    STB = 1'b1;
    repeat (3) @(negedge clk);
    STB = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic hub_shift_stb(input logic [5:0] d, input logic [3:0] r);
    {B2, G2, R2, B1, G1, R1} = d;
    {D, C, B, A} = r;
    repeat (2) @(negedge clk);
    I_CLK = 1'b1;
    STB = 1'b1;
    repeat (3) @(negedge clk);
    I_CLK = 1'b0;
    STB = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic shift_n(input int n);
    for (int i = 0; i < n; i++) hub_shift(row_data[i]);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 80; i++) row_data[i] = 6'($urandom_range(0, 63));
  endtask

  // Expected row image: first min(n,64) shifted values, zero beyond.
  task automatic build_exp(input int n, input int r);
    for (int c = 0; c < 64; c++) exp_px[c] = (c < n) ? row_data[c] : 6'd0;
    exp_base = r * 64;
  endtask

  // mode 0: ready high, 1: ready toggling, 2: ready random
  task automatic drain_check(input string name, input int mode, input int stop_after);
    int idx = 0;
    int cyc = 0;
    bit stalled = 0;
    bit rdy;
    while (idx < stop_after && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        total++;
        if (o_px_valid !== 1'b1 || o_px_addr !== 10'(exp_base + idx) || o_px_data !== exp_px[idx]) begin
          bad++;
          $display("FAIL %s hold col %0d: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                   name, idx, o_px_valid, o_px_addr, o_px_data, exp_base + idx, exp_px[idx]);
        end
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
      i_px_ready = rdy;
      if (o_px_valid === 1'b1) begin
        if (rdy) begin
          total++;
          if (o_px_addr !== 10'(exp_base + idx) || o_px_data !== exp_px[idx]) begin
            bad++;
            $display("FAIL %s write %0d: addr=%0d data=%h, required addr=%0d data=%h",
                     name, idx, o_px_addr, o_px_data, exp_base + idx, exp_px[idx]);
          end
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
        end
      end else begin
        stalled = 0;
      end
    end
    if (idx < stop_after) begin
      total++;
      bad++;
      $display("FAIL %s timeout: accepted=%0d, required %0d", name, idx, stop_after);
    end
    if (stop_after == 64) begin
      i_px_ready = 1'b1;
      @(negedge clk);
      total++;
      if (o_px_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s extra write: valid=%b addr=%0d, required valid=0", name, o_px_valid, o_px_addr);
      end
      i_px_ready = 1'b0;
    end
  endtask

  task automatic check_errs(input string name, input int l0, input int o0, input int el, input int eo);
    total++;
    if (n_len - l0 !== el) begin
      bad++;
      $display("FAIL %s err_len pulses=%0d, required %0d", name, n_len - l0, el);
    end
    total++;
    if (n_ovr - o0 !== eo) begin
      bad++;
      $display("FAIL %s err_ovr pulses=%0d, required %0d", name, n_ovr - o0, eo);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({o_px_valid, o_px_addr, o_px_data, o_oe_valid, o_oe_cycles, o_oe_row, o_err_len, o_err_ovr} !== '0) begin
      bad++;
      $display("FAIL %s outputs: valid=%b addr=%0d data=%h oe_v=%b oe_c=%0d oe_r=%0d el=%b eo=%b, required all 0",
               name, o_px_valid, o_px_addr, o_px_data, o_oe_valid, o_oe_cycles, o_oe_row, o_err_len, o_err_ovr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_all_zero("post_reset");
  endtask

  task automatic test_basic(input string name, input int mode);
    int l0, o0;
    for (int k = 0; k < 80; k++) row_data[k] = 6'((((k >> 1) & 1) << 4) | (k & 1));
    shift_n(64);
    l0 = n_len; o0 = n_ovr;
    hub_stb(4'd5);
    build_exp(64, 5);
    drain_check(name, mode, 64);
    check_errs(name, l0, o0, 0, 0);
  endtask

  task automatic test_short();
    int l0, o0;
    fill_random();
    shift_n(10);
    l0 = n_len; o0 = n_ovr;
    hub_stb(4'd0);
    build_exp(10, 0);
    drain_check("short", 2, 64);
    check_errs("short", l0, o0, 1, 0);
  endtask

  task automatic test_same_cycle();
    int l0, o0;
    logic [3:0] r;
    fill_random();
    r = 4'($urandom_range(0, 15));
    shift_n(63);
    l0 = n_len; o0 = n_ovr;
    hub_shift_stb(row_data[63], r);
    build_exp(64, r);
    drain_check("same_cycle", 0, 64);
    check_errs("same_cycle", l0, o0, 0, 0);
  endtask

  task automatic test_random();
    int n, l0, o0;
    logic [3:0] r;
    oe_noise = 1;
    for (int it = 0; it < 5; it++) begin
      fill_random();
      n = ($urandom_range(0, 2) == 0) ? 64 : int'($urandom_range(1, 70));
      if (it == 0) n = 70;
      r = 4'($urandom_range(0, 15));
      shift_n(n);
      l0 = n_len; o0 = n_ovr;
      hub_stb(r);
      build_exp(n, r);
      drain_check("random", 2, 64);
      check_errs("random", l0, o0, (n < 64) ? 1 : 0, 0);
    end
    oe_noise = 0;
    OE = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic oe_pulse_check(input string name, input int len, input logic [3:0] r);
    int c0;
    c0 = n_oe;
    OE = 1'b1;
    repeat (len) @(negedge clk);
    OE = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (n_oe - c0 !== 1) begin
      bad++;
      $display("FAIL %s oe_valid pulses=%0d, required 1", name, n_oe - c0);
    end
    total++;
    if (last_oe_cycles !== 16'(len) || last_oe_row !== r) begin
      bad++;
      $display("FAIL %s oe report cycles=%0d row=%0d, required cycles=%0d row=%0d",
               name, last_oe_cycles, last_oe_row, len, r);
    end
  endtask

  task automatic test_oe();
    fill_random();
    shift_n(64);
    hub_stb(4'd3);
    build_exp(64, 3);
    drain_check("oe_row", 0, 64);
    oe_pulse_check("oe8", 8, 4'd3);
    for (int i = 0; i < 3; i++) oe_pulse_check("oe_rand", int'($urandom_range(1, 40)), 4'd3);
  endtask

  task automatic test_overrun();
    int l0, o0;
    fill_random();
    shift_n(64);
    hub_stb(4'd5);
    build_exp(64, 5);
    for (int i = 0; i < 3; i++) hub_shift(6'h3f);
    l0 = n_len; o0 = n_ovr;
    hub_stb(4'd9);
    check_errs("overrun", l0, o0, 1, 1);
    drain_check("overrun_drain", 2, 64);
    fill_random();
    shift_n(5);
    l0 = n_len; o0 = n_ovr;
    hub_stb(4'd1);
    build_exp(5, 1);
    drain_check("after_overrun", 0, 64);
    check_errs("after_overrun", l0, o0, 1, 0);
  endtask

  task automatic test_reset_mid_drain();
    logic [3:0] r;
    fill_random();
    r = 4'($urandom_range(0, 15));
    shift_n(64);
    hub_stb(r);
    build_exp(64, r);
    drain_check("pre_reset", 0, 20);
    @(negedge clk);
    i_px_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_drain");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    fill_random();
    r = 4'($urandom_range(0, 15));
    shift_n(64);
    hub_stb(r);
    build_exp(64, r);
    drain_check("fresh_after_reset", 2, 64);
  endtask

  initial begin
    test_reset();
    test_basic("basic", 0);
    test_basic("stall", 1);
    test_short();
    test_same_cycle();
    test_random();
    test_oe();
    test_overrun();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
